// File: rtl/buff_uart_rx_fifo.sv
// buff_uart_rx_fifo: receive front end of the buffered UART.
// Deserialises the asynchronous rx line (8N1, LSB first) and pushes each good word into a small
// FIFO. The FIFO is popped by bus reads addressed to rx_address.
// Ports:
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   rx                serial line, idle high, asynchronous to clk
//   read_enable       bus read strobe, qualified by active_address == rx_address
//   active_address    bus address
//   data              registered read data (0 when popping an empty FIFO)
//   fifo_count        words currently held; empty/full derived from it, all registered
//   overrun           sticky: good frame dropped because the FIFO was full
//   frame_err         sticky: stop bit sampled low
//   err_clear         synchronous clear of overrun and frame_err (wins over a same-cycle set)
module buff_uart_rx_fifo #(
  parameter int unsigned width         = 8,
  parameter int unsigned fifo_length   = 4,
  parameter int unsigned address_width = 4,
  parameter int unsigned rx_address    = 0,
  parameter int unsigned baud_rate     = 9600,
  parameter int unsigned clock_freq    = 460800
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx,
  input  logic                               read_enable,
  input  logic [address_width-1:0]           active_address,
  output logic [width-1:0]                   data,
  output logic [$clog2(fifo_length+1)-1:0]   fifo_count,
  output logic                               empty,
  output logic                               full,
  output logic                               overrun,
  output logic                               frame_err,
  input  logic                               err_clear
);

  localparam int unsigned Cpb    = clock_freq / baud_rate;
  localparam int unsigned CntW   = $clog2(Cpb);
  localparam int unsigned BitW   = (width > 1) ? $clog2(width) : 1;
  localparam int unsigned PtrW   = $clog2(fifo_length);
  localparam int unsigned CountW = $clog2(fifo_length + 1);

  localparam logic [CntW-1:0]          CntHalf   = CntW'(Cpb / 2 - 1);
  localparam logic [CntW-1:0]          CntLast   = CntW'(Cpb - 1);
  localparam logic [CntW-1:0]          CntOne    = CntW'(1);
  localparam logic [BitW-1:0]          BitLast   = BitW'(width - 1);
  localparam logic [BitW-1:0]          BitOne    = BitW'(1);
  localparam logic [PtrW-1:0]          PtrLast   = PtrW'(fifo_length - 1);
  localparam logic [PtrW-1:0]          PtrOne    = PtrW'(1);
  localparam logic [CountW-1:0]        CountOne  = CountW'(1);
  localparam logic [CountW-1:0]        CountFull = CountW'(fifo_length);
  localparam logic [address_width-1:0] RxAddr    = address_width'(rx_address);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  // Synchroniser
  logic rx_meta_q, rx_s_q;

  // Receiver
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [width-1:0]  shift_q, shift_d;
  logic              push_req, stop_bad;

  // FIFO and bus side
  logic [width-1:0]  mem_q [fifo_length];
  logic [width-1:0]  mem_d [fifo_length];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic [width-1:0]  data_q, data_d;
  logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic              pop, pop_ok, push_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Recheck at mid start bit so short glitches are ignored.
        if (cnt_q == CntHalf) begin
          if (!rx_s_q) begin
            state_d = StData;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          bit_d          = bit_q + BitOne;
          if (bit_q == BitLast) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StWaitHi;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitHi: begin
        // Hold off until the line goes idle so a break is not read as frames.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop     = read_enable && (active_address == RxAddr);
    pop_ok  = pop && !empty_q;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the word.
    push_ok = push_req && (!full_q || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
    end
    if (pop) begin
      data_d = pop_ok ? mem_q[rd_ptr_q] : '0;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CountOne;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CountOne;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CountFull);

    overrun_d = overrun_q;
    if (err_clear) begin
      overrun_d = 1'b0;
    end else if (push_req && !push_ok) begin
      overrun_d = 1'b1;
    end

    frame_err_d = frame_err_q;
    if (err_clear) begin
      frame_err_d = 1'b0;
    end else if (stop_bad) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      for (int i = 0; i < int'(fifo_length); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign fifo_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_buff_uart_rx_fifo.sv
// Bench for buff_uart_rx_fifo: directed frames and bus reads, a queue-based reference model
// compared against the DUT on every settled cycle, plus hand-computed literal checks.
module tb_buff_uart_rx_fifo;

  localparam int CPB     = 48;
  localparam int DEPTH   = 4;
  localparam int RX_ADDR = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       read_enable = 1'b0;
  logic [3:0] active_address = 4'd0;
  logic       err_clear = 1'b0;
  logic [7:0] data;
  logic [2:0] fifo_count;
  logic       empty, full, overrun, frame_err;

  buff_uart_rx_fifo #(
    .width(8), .fifo_length(4), .address_width(4), .rx_address(0),
    .baud_rate(9600), .clock_freq(460800)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .read_enable(read_enable),
    .active_address(active_address), .data(data), .fifo_count(fifo_count),
    .empty(empty), .full(full), .overrun(overrun), .frame_err(frame_err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents, last read data and sticky flags.
  logic [7:0] m_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;
  bit         settled = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (settled && rst_n) begin
      chk("m_count", 32'(fifo_count), 32'(m_q.size()));
      chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("m_overrun", 32'(overrun), 32'(m_ov));
      chk("m_frame_err", 32'(frame_err), 32'(m_fe));
      chk("m_data", 32'(data), 32'(m_data));
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    settled = 1'b0;
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (!stop) begin
      if (!err_clear) m_fe = 1'b1;
    end else if (m_q.size() >= DEPTH) begin
      if (!err_clear) m_ov = 1'b1;
    end else begin
      m_q.push_back(b);
    end
    settled = 1'b1;
  endtask

  task automatic do_read(input logic [3:0] addr);
    @(posedge clk); #1;
    read_enable    = 1'b1;
    active_address = addr;
    @(posedge clk); #1;
    read_enable    = 1'b0;
    active_address = 4'd0;
    if (addr == 4'(RX_ADDR)) begin
      if (m_q.size() > 0) m_data = m_q.pop_front();
      else m_data = 8'h00;
    end
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 settled = 1'b1;

    // 1: single frame, push latency, read back
    n = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!seen && n < 600) begin
          @(posedge clk); #1;
          n++;
          if (fifo_count == 3'd1) seen = 1'b1;
        end
      end
    join
    checks++;
    if (!seen || n < 440 || n > 480) begin
      errors++;
      $display("FAIL t1_push_latency actual=%0d required=440..480", n);
    end
    do_read(4'(RX_ADDR));
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_empty", 32'(empty), 32'h1);

    // 2: fill to full, overrun on the fifth, drain in order
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 4) chk("t2_full_after_4", 32'(full), 32'h1);
    end
    chk("t2_overrun", 32'(overrun), 32'h1);
    chk("t2_count", 32'(fifo_count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      do_read(4'(RX_ADDR));
      chk("t2_read", 32'(data), 32'(i));
    end
    chk("t2_empty", 32'(empty), 32'h1);
    clear_errors();
    #0 chk("t2_overrun_cleared", 32'(overrun), 32'h0);

    // 3: short glitch is ignored
    @(posedge clk); #1 rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t3_count", 32'(fifo_count), 32'h0);
    chk("t3_frame_err", 32'(frame_err), 32'h0);
    chk("t3_overrun", 32'(overrun), 32'h0);

    // 4: bad stop bit, break held low, recovery
    send_frame(8'h3C, 1'b0);
    chk("t4_frame_err", 32'(frame_err), 32'h1);
    chk("t4_count", 32'(fifo_count), 32'h0);
    @(posedge clk); #1 rx = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("t4_break_no_push", 32'(fifo_count), 32'h0);
    send_frame(8'h55, 1'b1);
    do_read(4'(RX_ADDR));
    chk("t4_data", 32'(data), 32'h55);
    clear_errors();
    // err_clear held across a bad frame wins over the set
    @(posedge clk); #1 err_clear = 1'b1;
    send_frame(8'hC3, 1'b0);
    chk("t4_clear_priority", 32'(frame_err), 32'h0);
    err_clear = 1'b0;

    // 5: read at another address, then empty read
    send_frame(8'h77, 1'b1);
    do_read(4'(RX_ADDR + 1));
    chk("t5_other_addr_data", 32'(data), 32'h55);
    chk("t5_other_addr_count", 32'(fifo_count), 32'h1);
    do_read(4'(RX_ADDR));
    chk("t5_data", 32'(data), 32'h77);
    do_read(4'(RX_ADDR));
    chk("t5_empty_read", 32'(data), 32'h00);
    chk("t5_empty", 32'(empty), 32'h1);

    // 6: async reset in the middle of a frame
    send_frame(8'h99, 1'b1);
    do_read(4'(RX_ADDR));
    chk("t6_pre_data", 32'(data), 32'h99);
    send_frame(8'h66, 1'b1);
    settled = 1'b0;
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_data", 32'(data), 32'h0);
    chk("t6_rst_count", 32'(fifo_count), 32'h0);
    chk("t6_rst_empty", 32'(empty), 32'h1);
    chk("t6_rst_full", 32'(full), 32'h0);
    chk("t6_rst_overrun", 32'(overrun), 32'h0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'h0);
    m_q.delete();
    m_data = 8'h00;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    settled = 1'b1;
    send_frame(8'h12, 1'b1);
    chk("t6_count", 32'(fifo_count), 32'h1);
    do_read(4'(RX_ADDR));
    chk("t6_data", 32'(data), 32'h12);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
